dmem_access_ctrl: RTL and testbench

Memory-stage access controller for the 5-stage RISC-V pipeline. It consumes the EX/MEM register outputs and issues word loads and stores on a request/grant/response data-memory bus. It drives `StallM` back to the pipeline, which holds the IF/ID/EX/MEM registers, until each access completes. It also supplies `ReadDataM` to the MEM/WB register.

---
 rtl/riscv_pkg.sv | 7 +
 rtl/timeout_counter.sv | 21 ++
 rtl/dmem_access_ctrl.sv | 109 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline's memory-stage access controller.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} dmem_state_t;

  localparam logic [1:0] RESULT_SRC_MEM       = 2'b01;
  localparam int         DMEM_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/timeout_counter.sv
// Watchdog for a bus phase: counts while enabled, flags the last permitted cycle.
module timeout_counter #(
  parameter int CNT_W          = 7,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CNT_W'(1);
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage word load/store controller on a req/gnt/rvalid bus.
// States: IDLE wait for op | REQ bus request | RESP wait rvalid | DONE release stall, results valid.
module dmem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        ErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  dmem_state_t state;
  logic is_load, is_store, op;
  logic cnt_clear, cnt_en, expired;

  assign is_load  = RegWriteM & (ResultSrcM == RESULT_SRC_MEM);
  assign is_store = MemWriteM;
  assign op       = is_load | is_store;
  assign StallM   = op & (state != DONE);

  // Counter restarts for the RESP phase on the grant edge.
  assign cnt_en    = (state == REQ) | (state == RESP);
  assign cnt_clear = ~cnt_en | ((state == REQ) & dmem_gnt);

  timeout_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ReadDataM  <= '0;
      ErrM       <= 1'b0;
    end else begin
      ErrM <= 1'b0;
      case (state)
        IDLE: begin
          if (op) begin
            if (ALUResultM[1:0] == 2'b00) begin
              dmem_addr  <= ALUResultM;
              dmem_we    <= is_store;
              dmem_wdata <= WriteDataM;
              dmem_req   <= 1'b1;
              state      <= REQ;
            end else begin
              ErrM      <= 1'b1;
              ReadDataM <= '0;
              state     <= DONE;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              ReadDataM <= '0;
              state     <= DONE;
            end else begin
              state <= RESP;
            end
          end else if (expired) begin
            dmem_req  <= 1'b0;
            ErrM      <= 1'b1;
            ReadDataM <= '0;
            state     <= DONE;
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            ReadDataM <= dmem_rdata;
            state     <= DONE;
          end else if (expired) begin
            ErrM      <= 1'b1;
            ReadDataM <= '0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table plus reset and back-to-back sequences.
module tb_dmem_access_ctrl;
  import riscv_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        ErrM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .ErrM(ErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    int          exp_stall;
    int          exp_req;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        exp_we;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0;
    ALUResultM = '0; WriteDataM = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  // Acts as pipeline plus bus responder; starts and ends 1 time unit after a rising edge.
  task automatic run_access(input vec_t v, output int stall_n, output int req_n,
                            output logic err, output logic [31:0] rd, output logic we_seen,
                            output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                            output logic req_done, output logic done_ok);
    int gnt_cyc;
    RegWriteM = v.rw; ResultSrcM = v.rs; MemWriteM = v.mw;
    ALUResultM = v.addr; WriteDataM = v.wdata; dmem_rdata = v.rdata;
    stall_n = 0; req_n = 0; err = 1'b0; rd = '0; we_seen = 1'b0;
    addr_seen = '0; wdata_seen = '0; req_done = 1'b0; done_ok = 1'b0; gnt_cyc = -1;
    for (int c = 0; c < 40 && !done_ok; c++) begin
      dmem_gnt    = dmem_req && (req_n == v.gnt_dly);
      dmem_rvalid = (gnt_cyc >= 0) && (c == gnt_cyc + v.rv_dly);
      if (dmem_req) begin
        req_n++;
        we_seen = dmem_we; addr_seen = dmem_addr; wdata_seen = dmem_wdata;
      end
      if (dmem_gnt) gnt_cyc = c;
      #1;
      if (StallM) stall_n++;
      else begin
        done_ok = 1'b1; err = ErrM; rd = ReadDataM; req_done = dmem_req;
      end
      @(posedge clock); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    end
    clear_inputs();
  endtask

  int          s_n, r_n;
  logic        e_v, we_v, rq_v, ok_v;
  logic [31:0] rd_v, a_v, wd_v;

  initial begin
    //                rw    rs     mw    addr          wdata         rdata        gnt rv stall req err   rd            we
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0,  0, 2,  1, 1'b0, 32'h0,        1'b1};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1, 3, 6,  2, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0,         32'h0,        0,  1, 1,  0, 1'b1, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0030, 32'h1111_2222, 32'h0,        99, 0, 9,  8, 1'b1, 32'h0,        1'b1};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0044, 32'h0,         32'hA5A5_0F0F, 0, 1, 3,  1, 1'b0, 32'hA5A5_0F0F, 1'b0};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0048, 32'h0,         32'h5555_AAAA, 0, 99, 10, 1, 1'b1, 32'h0,       1'b0};
    vecs[6]  = '{1'b1, 2'b01, 1'b1, 32'h0000_0050, 32'hCAFE_F00D, 32'h7777_7777, 0, 1, 2,  1, 1'b0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0054, 32'h0BAD_CAFE, 32'h0,        7,  0, 9,  8, 1'b0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h3333_3333, 32'h0,        0,  0, 1,  0, 1'b1, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0060, 32'h0,         32'h0,        0,  0, 0,  0, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0064, 32'h0,         32'h0,        0,  0, 0,  0, 1'b0, 32'h0,        1'b0};

    reset = 1'b1;
    clear_inputs();
    #12;
    check("rst_req",   32'(dmem_req),  32'h0);
    check("rst_we",    32'(dmem_we),   32'h0);
    check("rst_addr",  dmem_addr,      32'h0);
    check("rst_wdata", dmem_wdata,     32'h0);
    check("rst_rdata", ReadDataM,      32'h0);
    check("rst_err",   32'(ErrM),      32'h0);
    check("rst_stall", 32'(StallM),    32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 11; i++) begin
      run_access(vecs[i], s_n, r_n, e_v, rd_v, we_v, a_v, wd_v, rq_v, ok_v);
      check($sformatf("v%0d_done", i),     32'(ok_v),  32'h1);
      check($sformatf("v%0d_stall", i),    32'(s_n),   32'(vecs[i].exp_stall));
      check($sformatf("v%0d_reqcyc", i),   32'(r_n),   32'(vecs[i].exp_req));
      check($sformatf("v%0d_err", i),      32'(e_v),   32'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i),    rd_v,       vecs[i].exp_rd);
      check($sformatf("v%0d_req_done", i), 32'(rq_v),  32'h0);
      check($sformatf("v%0d_err_after", i), 32'(ErrM), 32'h0);
      if (vecs[i].exp_req > 0) begin
        check($sformatf("v%0d_we", i),   32'(we_v), 32'(vecs[i].exp_we));
        check($sformatf("v%0d_addr", i), a_v,       vecs[i].addr);
        if (vecs[i].exp_we) check($sformatf("v%0d_wdata", i), wd_v, vecs[i].wdata);
      end
    end

    // Back-to-back store to 0x0 then load from 0x4.
    run_access('{1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_00AA, 32'h0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0},
               s_n, r_n, e_v, rd_v, we_v, a_v, wd_v, rq_v, ok_v);
    check("b2b_st_req",   32'(r_n),  32'h1);
    check("b2b_st_we",    32'(we_v), 32'h1);
    check("b2b_st_addr",  a_v,       32'h0);
    check("b2b_st_stall", 32'(s_n),  32'h2);
    run_access('{1'b1, 2'b01, 1'b0, 32'h4, 32'h0, 32'h0000_BEEF, 0, 1, 0, 0, 1'b0, 32'h0, 1'b0},
               s_n, r_n, e_v, rd_v, we_v, a_v, wd_v, rq_v, ok_v);
    check("b2b_ld_req",   32'(r_n),  32'h1);
    check("b2b_ld_we",    32'(we_v), 32'h0);
    check("b2b_ld_addr",  a_v,       32'h4);
    check("b2b_ld_stall", 32'(s_n),  32'h3);
    check("b2b_ld_rdata", rd_v,      32'h0000_BEEF);

    // Reset while a load to 0x40 waits in RESP.
    RegWriteM = 1'b1; ResultSrcM = 2'b01; ALUResultM = 32'h40;
    @(posedge clock); #1;
    check("rr_req_in_req", 32'(dmem_req), 32'h1);
    dmem_gnt = 1'b1;
    @(posedge clock); #1;
    dmem_gnt = 1'b0;
    check("rr_req_after_gnt", 32'(dmem_req), 32'h0);
    check("rr_stall_resp",    32'(StallM),   32'h1);
    #2 reset = 1'b1;
    #1;
    check("rr_state_idle", 32'(dut.state), 32'(IDLE));
    check("rr_rdata_rst",  ReadDataM,      32'h0);
    clear_inputs();
    #2 reset = 1'b0;
    @(posedge clock); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #1;
    dmem_rvalid = 1'b0;
    check("rr_late_rvalid", ReadDataM, 32'h0);
    check("rr_no_err",      32'(ErrM), 32'h0);
    check("rr_stall_low",   32'(StallM), 32'h0);

    // Reset in REQ drops the request before any clock edge.
    MemWriteM = 1'b1; ALUResultM = 32'h60; WriteDataM = 32'h1;
    @(posedge clock); #1;
    check("ar_req_high", 32'(dmem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("ar_req_async", 32'(dmem_req), 32'h0);
    clear_inputs();
    #2 reset = 1'b0;
    @(posedge clock); #1;
    check("ar_req_idle", 32'(dmem_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
